// File: rtl/multdiv_if.sv
// ============================================================================
// Module      : multdiv_if
// Description : Operand, control and result bundle between the decoder/X-M
//               latch and the iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multdiv_if;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  // Decoder / pipeline side: issues operations, consumes results.
  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );

  // Unit side.
  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

`default_nettype wire

// File: rtl/multdiv.sv
// ============================================================================
// Module      : multdiv
// Description : Iterative signed 32-bit multiply (radix-2 shift-add) and
//               divide (restoring, on magnitudes). Fixed 33-cycle latency,
//               registered result/exception, one-cycle ready strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv (
  input  logic     clock,
  input  logic     reset,
  multdiv_if.slave bus
);

  localparam logic [5:0]  c_LAST_STEP = 6'd31;
  localparam logic [5:0]  c_STEPS     = 6'd32;
  localparam logic [31:0] c_INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;

  // Multiply datapath
  logic [63:0] acc_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;

  // Divide datapath
  logic [32:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvsr_q;
  logic        qneg_q;
  logic        dzero_q;
  logic        dovf_q;

  // Registered outputs
  logic [31:0] result_q;
  logic        exc_q;
  logic        rdy_q;
  logic        busy_q;

  // Combinational next values
  logic        w_start;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [63:0] w_pp;
  logic [63:0] acc_d;
  logic [33:0] w_trial;
  logic [32:0] rem_d;
  logic [31:0] quo_d;
  logic [32:0] w_prod_hi;
  logic        w_mul_exc;
  logic [31:0] w_div_res;
  logic        w_div_exc;

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;

  // Single-step datapath for both operations plus final result shaping.
  always_comb begin
    w_start = bus.ctrl_MULT | bus.ctrl_DIV;
    w_abs_a = bus.data_operandA[31] ? (32'd0 - bus.data_operandA) : bus.data_operandA;
    w_abs_b = bus.data_operandB[31] ? (32'd0 - bus.data_operandB) : bus.data_operandB;

    // Bit 31 of a two's-complement multiplier carries weight -2^31, so the
    // last partial product is subtracted instead of added.
    w_pp  = mplier_q[0] ? mcand_q : 64'd0;
    acc_d = (cnt_q == c_LAST_STEP) ? (acc_q - w_pp) : (acc_q + w_pp);

    // Restoring step: shift next dividend bit into the remainder and keep
    // the difference only when it is non-negative.
    w_trial = {rem_q, quo_q[31]} - {2'b00, dvsr_q};
    rem_d   = w_trial[33] ? {rem_q[31:0], quo_q[31]} : w_trial[32:0];
    quo_d   = {quo_q[30:0], ~w_trial[33]};

    w_prod_hi = acc_q[63:31];
    w_mul_exc = (w_prod_hi != 33'd0) && (w_prod_hi != {33{1'b1}});

    w_div_res = 32'd0;
    w_div_exc = 1'b0;
    if (dzero_q) begin
      w_div_res = 32'd0;
      w_div_exc = 1'b1;
    end else if (dovf_q) begin
      w_div_res = c_INT_MIN;
      w_div_exc = 1'b1;
    end else begin
      w_div_res = qneg_q ? (32'd0 - quo_q) : quo_q;
      w_div_exc = 1'b0;
    end
  end

  // Control FSM, iteration registers and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      rem_q    <= 33'd0;
      quo_q    <= 32'd0;
      dvsr_q   <= 32'd0;
      qneg_q   <= 1'b0;
      dzero_q  <= 1'b0;
      dovf_q   <= 1'b0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else if (w_start) begin
      // A start in any state abandons whatever was in flight.
      state_q  <= bus.ctrl_MULT ? S_MUL : S_DIV;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      mcand_q  <= {{32{bus.data_operandA[31]}}, bus.data_operandA};
      mplier_q <= bus.data_operandB;
      rem_q    <= 33'd0;
      quo_q    <= w_abs_a;
      dvsr_q   <= w_abs_b;
      qneg_q   <= bus.data_operandA[31] ^ bus.data_operandB[31];
      dzero_q  <= (bus.data_operandB == 32'd0);
      dovf_q   <= (bus.data_operandA == c_INT_MIN) && (bus.data_operandB == 32'hFFFF_FFFF);
      rdy_q    <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      case (state_q)
        S_MUL: begin
          if (cnt_q == c_STEPS) begin
            state_q  <= S_DONE;
            result_q <= acc_q[31:0];
            exc_q    <= w_mul_exc;
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= {mcand_q[62:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[31:1]};
            cnt_q    <= cnt_q + 6'd1;
          end
        end
        S_DIV: begin
          if (cnt_q == c_STEPS) begin
            state_q  <= S_DONE;
            result_q <= w_div_res;
            exc_q    <= w_div_exc;
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 6'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          rdy_q   <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          rdy_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multdiv.sv
// ============================================================================
// Module      : tb_multdiv
// Description : Scoreboard bench for multdiv. The driver pushes expected
//               results (value, flag, strobe edge) into a queue; a monitor
//               pops and compares on every ready strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multdiv;

  logic clock;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_pass;

  multdiv_if bus();

  multdiv dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          edge_no;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t got;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (bus.data_resultRDY === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 64'(cyc), 64'hFFFF_FFFF);
      end else begin
        got = sb.pop_front();
        chk({got.name, "_result"}, 64'(bus.data_result), 64'(got.res));
        chk({got.name, "_exc"}, 64'(bus.data_exception), 64'(got.exc));
        chk({got.name, "_edge"}, 64'(cyc), 64'(got.edge_no));
      end
    end
  end

  // Issue one operation, expect its strobe 33 edges later, and check that
  // busy is high after edges 0..32 and low after edge 33.
  task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er,
                        input logic ee, input string nm);
    logic [33:0] prof;
    exp_t        e;
    @(negedge clock);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    @(posedge clock);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = 32'hDEAD_BEEF;
    bus.data_operandB = 32'h1234_5678;
    prof[0]   = bus.busy;
    e.res     = er;
    e.exc     = ee;
    e.edge_no = cyc + 33;
    e.name    = nm;
    sb.push_back(e);
    for (int k = 1; k <= 33; k++) begin
      @(posedge clock);
      #1;
      prof[k] = bus.busy;
    end
    chk({nm, "_busy"}, 64'(prof), 64'(34'h1_FFFF_FFFF));
  endtask

  task automatic pulse(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    @(posedge clock);
    #1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
  endtask

  initial begin
    logic seen;
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    reset    = 1'b1;
    bus.data_operandA = 32'd0;
    bus.data_operandB = 32'd0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_result", 64'(bus.data_result), 64'd0);
    chk("reset_exc",    64'(bus.data_exception), 64'd0);
    chk("reset_rdy",    64'(bus.data_resultRDY), 64'd0);
    chk("reset_busy",   64'(bus.busy), 64'd0);
    reset = 1'b0;

    run_op(1, 0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 0, "mul_7x-6");
    run_op(1, 0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1, "mul_ovf");
    run_op(1, 0, 32'h8000_0000,  32'd1,         32'h8000_0000, 0, "mul_min");
    run_op(1, 0, 32'hFFFF_FFFB,  32'hFFFF_FFFB, 32'd25,        0, "mul_-5x-5");
    run_op(0, 1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0, "div_-7/2");
    run_op(0, 1, 32'd100,        32'hFFFF_FFF6, 32'hFFFF_FFF6, 0, "div_100/-10");
    run_op(0, 1, 32'd5,          32'd0,         32'd0,         1, "div_by0");
    run_op(0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run_op(0, 1, 32'hFFFF_CFC7,  32'hFFFF_FFF9, 32'h0000_06E3, 0, "div_-12345/-7");

    // Multiply abandoned by a divide started on edge 10.
    pulse(1, 0, 32'd3, 32'd3);
    repeat (9) @(posedge clock);
    run_op(0, 1, 32'd9, 32'd3, 32'd3, 0, "restart_div");

    run_op(1, 1, 32'd2, 32'd5, 32'd10, 0, "both_ctrl");

    // Reset at edge 15 of a multiply; starts during reset are ignored.
    pulse(1, 0, 32'd11, 32'd13);
    repeat (15) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midrst_result", 64'(bus.data_result), 64'd0);
    chk("midrst_exc",    64'(bus.data_exception), 64'd0);
    chk("midrst_rdy",    64'(bus.data_resultRDY), 64'd0);
    chk("midrst_busy",   64'(bus.busy), 64'd0);
    @(negedge clock);
    bus.ctrl_MULT = 1'b1;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      seen = seen | bus.busy | bus.data_resultRDY;
    end
    chk("post_rst_quiet", 64'(seen), 64'd0);

    run_op(1, 0, 32'd3, 32'd4, 32'd12, 0, "fresh_mul");

    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clock);
    chk("outstanding", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
